// File: rtl/word_serializer_32to1_if.sv
// Word-in / bit-out handshake bundle for word_serializer_32to1.
// slave = serializer side, master = producer/consumer side.
interface word_serializer_32to1_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_word;
   logic             ser_ready;
   logic             ser_valid;
   logic             ser_bit;
   logic             ser_last;
   logic             busy;

   modport slave (
      input  in_valid, in_word, ser_ready,
      output in_ready, ser_valid, ser_bit, ser_last, busy
   );

   modport master (
      output in_valid, in_word, ser_ready,
      input  in_ready, ser_valid, ser_bit, ser_last, busy
   );
endinterface

// File: rtl/word_serializer_32to1.sv
// Parallel-to-serial converter: one WIDTH-bit word in, one bit per handshake out.
// Optional trailing even-parity bit when WORD_SERIALIZER_PARITY_EN is defined.
module word_serializer_32to1 #(
   parameter int WIDTH     = 32,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   word_serializer_32to1_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;
`ifdef WORD_SERIALIZER_PARITY_EN
   localparam bit HAS_PAR = 1'b1;
`else
   localparam bit HAS_PAR = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
`ifdef WORD_SERIALIZER_PARITY_EN
      PAR,
`endif
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             ser_valid_q, ser_valid_d;
   logic             ser_bit_q, ser_bit_d;
   logic             ser_last_q, ser_last_d;
   logic             busy_q, busy_d;
`ifdef WORD_SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   logic             first_bit;
   logic             next_bit;
   logic [WIDTH-1:0] sreg_shifted;

   // The output end of the shift register depends on bit order.
   always_comb begin
      if (LSB_FIRST) begin
         first_bit    = bus.in_word[0];
         next_bit     = sreg_q[1];
         sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
      end else begin
         first_bit    = bus.in_word[WIDTH-1];
         next_bit     = sreg_q[WIDTH-2];
         sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      ser_valid_d = ser_valid_q;
      ser_bit_d   = ser_bit_q;
      ser_last_d  = ser_last_q;
      busy_d      = busy_q;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_d       = par_q;
`endif

      unique case (state_q)
         IDLE: begin
            in_ready_d  = 1'b1;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
            busy_d      = 1'b0;
            // Acceptance needs the registered in_ready, so the first edge after reset only opens the port.
            if (in_ready_q && bus.in_valid) begin
               state_d     = SHIFT;
               sreg_d      = bus.in_word;
               cnt_d       = '0;
               in_ready_d  = 1'b0;
               ser_valid_d = 1'b1;
               ser_bit_d   = first_bit;
               busy_d      = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
               par_d       = ^bus.in_word;
`endif
            end
         end

         SHIFT: begin
            if (bus.ser_ready) begin
               sreg_d = sreg_shifted;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                  state_d    = PAR;
                  ser_bit_d  = par_q;
                  ser_last_d = 1'b1;
`else
                  state_d     = IDLE;
                  in_ready_d  = 1'b1;
                  ser_valid_d = 1'b0;
                  ser_last_d  = 1'b0;
                  busy_d      = 1'b0;
`endif
               end else begin
                  ser_bit_d  = next_bit;
                  ser_last_d = !HAS_PAR && (cnt_q == CW'(WIDTH - 2));
               end
            end
         end

`ifdef WORD_SERIALIZER_PARITY_EN
         PAR: begin
            if (bus.ser_ready) begin
               state_d     = IDLE;
               in_ready_d  = 1'b1;
               ser_valid_d = 1'b0;
               ser_last_d  = 1'b0;
               busy_d      = 1'b0;
            end
         end
`endif

         default: state_d = IDLE;
      endcase
   end

   // Reset clears the shift register too, so an aborted frame leaves no residue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_bit_q   <= 1'b0;
         ser_last_q  <= 1'b0;
         busy_q      <= 1'b0;
`ifdef WORD_SERIALIZER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         ser_valid_q <= ser_valid_d;
         ser_bit_q   <= ser_bit_d;
         ser_last_q  <= ser_last_d;
         busy_q      <= busy_d;
`ifdef WORD_SERIALIZER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.ser_valid = ser_valid_q;
   assign bus.ser_bit   = ser_bit_q;
   assign bus.ser_last  = ser_last_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_word_serializer_32to1.sv
// Directed bench for word_serializer_32to1: one LSB-first and one MSB-first instance.
// Expected streams come from the bench's own bit-order/parity model.
module tb_word_serializer_32to1;
   localparam int W = 32;
`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int NBITS = W + 1;
`else
   localparam int NBITS = W;
`endif

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   word_serializer_32to1_if #(.WIDTH(W)) l_if ();
   word_serializer_32to1_if #(.WIDTH(W)) m_if ();

   word_serializer_32to1 #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (l_if.slave)
   );

   word_serializer_32to1 #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
      .clk   (clk),
      .reset (reset),
      .bus   (m_if.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_bit(input bit lsb, input logic [W-1:0] w, input int k);
      if (k >= W) return ^w;
      return lsb ? w[k] : w[W-1-k];
   endfunction

   function automatic logic g_valid(input bit sel);
      return sel ? m_if.ser_valid : l_if.ser_valid;
   endfunction
   function automatic logic g_bit(input bit sel);
      return sel ? m_if.ser_bit : l_if.ser_bit;
   endfunction
   function automatic logic g_last(input bit sel);
      return sel ? m_if.ser_last : l_if.ser_last;
   endfunction
   function automatic logic g_ready(input bit sel);
      return sel ? m_if.in_ready : l_if.in_ready;
   endfunction
   function automatic logic g_busy(input bit sel);
      return sel ? m_if.busy : l_if.busy;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit sel, input logic v, input logic [W-1:0] w);
      if (sel) begin m_if.in_valid = v; m_if.in_word = w; end
      else     begin l_if.in_valid = v; l_if.in_word = w; end
   endtask

   task automatic set_sready(input bit sel, input logic r);
      if (sel) m_if.ser_ready = r;
      else     l_if.ser_ready = r;
   endtask

   // Presents w, waits (bounded) for in_ready, clocks the accepting edge.
   task automatic send_word(input bit sel, input logic [W-1:0] w, output int acc_cyc);
      int i;
      set_in(sel, 1'b1, w);
      for (i = 0; i < 100 && !g_ready(sel); i++) tick();
      if (!g_ready(sel)) check("in_ready_timeout", 0, 1);
      tick();
      acc_cyc = cyc;
      set_in(sel, 1'b0, '0);
      check("accept_ser_valid", g_valid(sel), 1);
      check("accept_busy", g_busy(sel), 1);
      check("accept_in_ready", g_ready(sel), 0);
   endtask

   // Consumes n bits of the frame for w; optional stall of len cycles at bit bp_at.
   task automatic recv_frame(input bit sel, input logic [W-1:0] w, input int n,
                             input int bp_at, input int bp_len);
      logic e;
      for (int k = 0; k < n; k++) begin
         e = exp_bit(sel == 1'b0, w, k);
         if (k == bp_at) begin
            set_sready(sel, 1'b0);
            for (int j = 0; j < bp_len; j++) begin
               tick();
               check("bp_valid", g_valid(sel), 1);
               check("bp_bit", g_bit(sel), e);
               check("bp_last", g_last(sel), k == NBITS - 1);
            end
            set_sready(sel, 1'b1);
         end
         check($sformatf("valid_b%0d", k), g_valid(sel), 1);
         check($sformatf("bit_b%0d", k), g_bit(sel), e);
         check($sformatf("last_b%0d", k), g_last(sel), k == NBITS - 1);
         check("in_ready_while_busy", g_ready(sel), 0);
         tick();
      end
      if (n == NBITS) begin
         check("end_ser_valid", g_valid(sel), 0);
         check("end_ser_last", g_last(sel), 0);
         check("end_in_ready", g_ready(sel), 1);
         check("end_busy", g_busy(sel), 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2;
      reset = 1'b1;
      l_if.in_valid = 1'b1; l_if.in_word = 32'h0000_0001; l_if.ser_ready = 1'b1;
      m_if.in_valid = 1'b0; m_if.in_word = '0;            m_if.ser_ready = 1'b1;

      // Reset held three cycles with in_valid asserted.
      repeat (3) begin
         tick();
         check("rst_in_ready", l_if.in_ready, 0);
         check("rst_ser_valid", l_if.ser_valid, 0);
         check("rst_busy", l_if.busy, 0);
         check("rst_ser_bit", l_if.ser_bit, 0);
         check("rst_ser_last", l_if.ser_last, 0);
      end
      reset = 1'b0;
      #1;
      check("rel_in_ready_pre_edge", l_if.in_ready, 0);
      tick();
      check("rel_in_ready", l_if.in_ready, 1);
      check("rel_ser_valid", l_if.ser_valid, 0);

      // Basic LSB-first frame; a second word is offered throughout and must wait.
      send_word(1'b0, 32'h0000_0001, a1);
      set_in(1'b0, 1'b1, 32'h1234_5678);
      recv_frame(1'b0, 32'h0000_0001, NBITS, -1, 0);
      send_word(1'b0, 32'h1234_5678, a2);
      check("frame_period", a2 - a1, NBITS + 1);
      recv_frame(1'b0, 32'h1234_5678, NBITS, -1, 0);

      // MSB-first frame.
      send_word(1'b1, 32'h8000_0003, a1);
      recv_frame(1'b1, 32'h8000_0003, NBITS, -1, 0);

      // Backpressure of 5 cycles at bit 7.
      send_word(1'b0, 32'hA5A5_A5A5, a1);
      recv_frame(1'b0, 32'hA5A5_A5A5, NBITS, 7, 5);

      // Reset mid-frame after 10 bits.
      send_word(1'b0, 32'hFFFF_FFFF, a1);
      recv_frame(1'b0, 32'hFFFF_FFFF, 10, -1, 0);
      reset = 1'b1;
      #1;
      check("abort_ser_valid", l_if.ser_valid, 0);
      check("abort_busy", l_if.busy, 0);
      check("abort_ser_bit", l_if.ser_bit, 0);
      check("abort_in_ready", l_if.in_ready, 0);
      tick();
      reset = 1'b0;
      tick();
      check("abort_rel_in_ready", l_if.in_ready, 1);
      send_word(1'b0, 32'h0000_0000, a1);
      recv_frame(1'b0, 32'h0000_0000, NBITS, -1, 0);

`ifdef WORD_SERIALIZER_PARITY_EN
      // Odd and even popcount words: parity bits 1 and 0.
      send_word(1'b0, 32'h0000_0007, a1);
      recv_frame(1'b0, 32'h0000_0007, NBITS, -1, 0);
      send_word(1'b0, 32'h0000_0003, a1);
      recv_frame(1'b0, 32'h0000_0003, NBITS, -1, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
